// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rrarb4_1.sv
// gf180mcu_fd_sc_mcu7t5v0__rrarb4_1: 4-way round-robin arbiter with break-before-make grants; optional hold timeout via GF180MCU_FD_SC_MCU7T5V0_RRARB4_TIMEOUT_EN
module gf180mcu_fd_sc_mcu7t5v0__rrarb4_1 #(
  parameter int unsigned MAXHOLD = 15
) (
  input  logic CLK,
  input  logic RST,
  input  logic R1,
  input  logic R2,
  input  logic R3,
  input  logic R4,
  output logic G1,
  output logic G2,
  output logic G3,
  output logic G4,
  output logic IDLE,
  inout  wire  VDD,
  inout  wire  VSS
);
  typedef enum logic {S_IDLE, S_GRANT} state_t;
  state_t state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] g_q, g_d;
  logic [3:0] req;
  logic [1:0] pick;
  logic hit;
  logic held;
  logic expire;
  logic unused_pins;
  assign req = {R4, R3, R2, R1};
  assign held = |(g_q & req);
  assign unused_pins = VDD ^ VSS ^ MAXHOLD[0];
`ifdef GF180MCU_FD_SC_MCU7T5V0_RRARB4_TIMEOUT_EN
  logic [7:0] hc_q, hc_d;
  assign expire = hc_q == 8'(MAXHOLD);
`else
  assign expire = 1'b0;
`endif
  // first requester at or after the pointer; scanning backwards lets the nearest one win
  always_comb begin
    pick = ptr_q;
    hit = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr_q + 2'(i)]) begin
        pick = ptr_q + 2'(i);
        hit = 1'b1;
      end
    end
  end
  // grant from idle only, release to idle on drop or timeout so a gap always separates grants
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    g_d = g_q;
`ifdef GF180MCU_FD_SC_MCU7T5V0_RRARB4_TIMEOUT_EN
    hc_d = hc_q;
`endif
    if (state_q == S_IDLE) begin
      if (hit) begin
        state_d = S_GRANT;
        g_d = 4'b0001 << pick;
        ptr_d = pick + 2'd1;
`ifdef GF180MCU_FD_SC_MCU7T5V0_RRARB4_TIMEOUT_EN
        hc_d = 8'd1;
`endif
      end
    end else if (!held || expire) begin
      state_d = S_IDLE;
      g_d = 4'b0000;
    end else begin
`ifdef GF180MCU_FD_SC_MCU7T5V0_RRARB4_TIMEOUT_EN
      hc_d = hc_q + 8'd1;
`endif
    end
  end
  // state registers with synchronous reset overriding everything
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      ptr_q <= 2'd0;
      g_q <= 4'b0000;
`ifdef GF180MCU_FD_SC_MCU7T5V0_RRARB4_TIMEOUT_EN
      hc_q <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      g_q <= g_d;
`ifdef GF180MCU_FD_SC_MCU7T5V0_RRARB4_TIMEOUT_EN
      hc_q <= hc_d;
`endif
    end
  end
  assign {G4, G3, G2, G1} = g_q;
  assign IDLE = ~|g_q;
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__rrarb4_1.sv
// tb_gf180mcu_fd_sc_mcu7t5v0__rrarb4_1: randomized and directed checks of the round-robin arbiter against a behavioural model
module tb_gf180mcu_fd_sc_mcu7t5v0__rrarb4_1;
  localparam int MAXH = 4;
`ifdef GF180MCU_FD_SC_MCU7T5V0_RRARB4_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic r1 = 1'b0, r2 = 1'b0, r3 = 1'b0, r4 = 1'b0;
  logic g1, g2, g3, g4, idle;
  wire vdd = 1'b1;
  wire vss = 1'b0;
  logic [3:0] g;
  int total = 0;
  int bad = 0;
  int cur = -1;
  int mptr = 0;
  int mhc = 0;
  always #5 clk = ~clk;
  assign g = {g4, g3, g2, g1};
  gf180mcu_fd_sc_mcu7t5v0__rrarb4_1 #(.MAXHOLD(MAXH)) dut (
    .CLK(clk), .RST(rst),
    .R1(r1), .R2(r2), .R3(r3), .R4(r4),
    .G1(g1), .G2(g2), .G3(g3), .G4(g4),
    .IDLE(idle), .VDD(vdd), .VSS(vss)
  );
  function automatic logic [3:0] mexp();
    return cur < 0 ? 4'b0000 : 4'(1 << cur);
  endfunction
  task automatic step(input logic [3:0] r, input logic rs);
    @(negedge clk);
    {r4, r3, r2, r1} = r;
    rst = rs;
    @(posedge clk);
    if (rs) begin
      cur = -1;
      mptr = 0;
      mhc = 0;
    end else if (cur < 0) begin
      for (int k = 0; k < 4; k++) begin
        if (cur < 0 && r[(mptr + k) % 4]) begin
          cur = (mptr + k) % 4;
          mptr = (cur + 1) % 4;
          mhc = 1;
        end
      end
    end else if (!r[cur] || (TO && mhc == MAXH)) begin
      cur = -1;
    end else begin
      mhc++;
    end
    #1;
  endtask
  task automatic test_reset();
    step(4'b1111, 1'b1);
    step(4'b1111, 1'b1);
    total++;
    if (g !== 4'b0000 || idle !== 1'b1) begin
      bad++;
      $display("FAIL reset_hold g=%b idle=%b want g=0000 idle=1", g, idle);
    end
    step(4'b1111, 1'b0);
    total++;
    if (g !== 4'b0001 || idle !== 1'b0) begin
      bad++;
      $display("FAIL reset_first_grant g=%b idle=%b want g=0001 idle=0", g, idle);
    end
  endtask
  task automatic test_rotation();
    logic [3:0] want;
    step(4'b1111, 1'b1);
    step(4'b1111, 1'b0);
    for (int n = 0; n < 4; n++) begin
      want = 4'(1 << n);
      for (int c = 0; c < 3; c++) begin
        total++;
        if (g !== want || g !== mexp()) begin
          bad++;
          $display("FAIL rotation_hold ch=%0d cyc=%0d g=%b want %b", n + 1, c, g, want);
        end
        if (c < 2) step(4'b1111, 1'b0);
      end
      step(4'b1111 & ~want, 1'b0);
      total++;
      if (g !== 4'b0000 || idle !== 1'b1) begin
        bad++;
        $display("FAIL rotation_gap ch=%0d g=%b idle=%b want 0000/1", n + 1, g, idle);
      end
      step(4'b1111, 1'b0);
    end
    total++;
    if (g !== 4'b0001) begin
      bad++;
      $display("FAIL rotation_wrap_g1 g=%b want 0001", g);
    end
  endtask
  task automatic test_wrap();
    step(4'b0000, 1'b1);
    step(4'b1000, 1'b0);
    total++;
    if (g !== 4'b1000) begin
      bad++;
      $display("FAIL wrap_g4 g=%b want 1000", g);
    end
    step(4'b0000, 1'b0);
    step(4'b1001, 1'b0);
    total++;
    if (g !== 4'b0001) begin
      bad++;
      $display("FAIL wrap_ptr0 g=%b want 0001", g);
    end
    step(4'b1001, 1'b0);
    step(4'b1000, 1'b0);
    total++;
    if (g !== 4'b0000) begin
      bad++;
      $display("FAIL wrap_gap g=%b want 0000", g);
    end
    step(4'b1000, 1'b0);
    total++;
    if (g !== 4'b1000) begin
      bad++;
      $display("FAIL wrap_then_g4 g=%b want 1000", g);
    end
  endtask
  task automatic test_timeout();
    logic want;
    step(4'b0000, 1'b1);
    for (int c = 0; c < 20; c++) begin
      step(4'b0010, 1'b0);
      want = TO ? (c % (MAXH + 1) != MAXH) : 1'b1;
      total++;
      if (g2 !== want || g !== mexp()) begin
        bad++;
        $display("FAIL timeout cyc=%0d g=%b want g2=%b model=%b", c, g, want, mexp());
      end
    end
  endtask
  task automatic test_reset_mid();
    step(4'b0000, 1'b1);
    step(4'b0100, 1'b0);
    total++;
    if (g !== 4'b0100) begin
      bad++;
      $display("FAIL midrst_g3 g=%b want 0100", g);
    end
    step(4'b1111, 1'b1);
    total++;
    if (g !== 4'b0000) begin
      bad++;
      $display("FAIL midrst_clear g=%b want 0000", g);
    end
    step(4'b1111, 1'b0);
    total++;
    if (g !== 4'b0001) begin
      bad++;
      $display("FAIL midrst_g1 g=%b want 0001", g);
    end
  endtask
  task automatic test_random();
    logic [3:0] prev;
    logic [3:0] r;
    logic rs;
    step(4'b0000, 1'b1);
    prev = g;
    for (int c = 0; c < 10000; c++) begin
      r = 4'($urandom);
      rs = $urandom_range(99) == 0;
      step(r, rs);
      total++;
      if (g !== mexp()) begin
        bad++;
        $display("FAIL random_model cyc=%0d r=%b rst=%b g=%b want %b", c, r, rs, g, mexp());
      end
      total++;
      if ($countones(g) > 1 || idle !== ~|g) begin
        bad++;
        $display("FAIL random_onehot cyc=%0d g=%b idle=%b want popcount<=1 idle=%b", c, g, idle, ~|g);
      end
      total++;
      if (prev != 4'b0000 && g != 4'b0000 && prev != g) begin
        bad++;
        $display("FAIL random_bbm cyc=%0d prev=%b g=%b want gap between grants", c, prev, g);
      end
      prev = g;
    end
  endtask
  initial begin
    test_reset();
    test_rotation();
    test_wrap();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
